// File: rtl/average_pkg.sv
// Shared width and rounding helpers for the multi-channel block averager.
package average_pkg;

    function automatic int unsigned bitwidth_accumulator(int unsigned bitwidth_sample,
                                                         int unsigned log2_sample_count);
        return bitwidth_sample + log2_sample_count;
    endfunction

    // Half an LSB of the shifted result; zero when no shift takes place.
    function automatic int unsigned rounding_constant(int unsigned log2_sample_count);
        if (log2_sample_count == 0) begin
            return 0;
        end
        return 1 << (log2_sample_count - 1);
    endfunction

    function automatic int unsigned bitwidth_channel(int unsigned channel_count);
        if (channel_count <= 1) begin
            return 1;
        end
        return $clog2(channel_count);
    endfunction

endpackage

// File: rtl/average_channels_if.sv
// Tagged sample stream in, tagged mean pulse out.
interface average_channels_if #(
    parameter int unsigned sample_width  = 12,
    parameter int unsigned channel_width = 2
);
    logic [sample_width-1:0]  sample_value;
    logic [channel_width-1:0] sample_channel;
    logic                     sample_valid;
    logic [sample_width-1:0]  mean_value;
    logic [channel_width-1:0] mean_channel;
    logic                     mean_valid;

    modport master (
        output sample_value, sample_channel, sample_valid,
        input  mean_value, mean_channel, mean_valid
    );

    modport slave (
        input  sample_value, sample_channel, sample_valid,
        output mean_value, mean_channel, mean_valid
    );
endinterface

// File: rtl/average_slot.sv
// One channel's accumulator, window counter and last completed mean.
// AVERAGE_ROUNDING_EN selects round-half-up instead of truncation.
module average_slot
    import average_pkg::*;
#(
    parameter int unsigned bitwidth_sample   = 12,
    parameter int unsigned log2_sample_count = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       add,
    input  logic                       clear,
    input  logic [bitwidth_sample-1:0] sample,
    output logic                       complete,
    output logic [bitwidth_sample-1:0] window_mean,
    output logic [bitwidth_sample-1:0] last_mean
);
    localparam int unsigned acc_width =
        bitwidth_accumulator(bitwidth_sample, log2_sample_count);
    // Keep one counter bit when the window is a single sample; it then never leaves zero.
    localparam int unsigned cnt_width = (log2_sample_count == 0) ? 1 : log2_sample_count;
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'((1 << log2_sample_count) - 1);
`ifdef AVERAGE_ROUNDING_EN
    localparam logic [acc_width-1:0] round_const =
        acc_width'(rounding_constant(log2_sample_count));
`else
    localparam logic [acc_width-1:0] round_const = '0;
`endif

    logic [acc_width-1:0]       acc_q, acc_d;
    logic [cnt_width-1:0]       cnt_q, cnt_d;
    logic [bitwidth_sample-1:0] last_mean_q, last_mean_d;
    logic [acc_width-1:0]       sum;
    logic [acc_width-1:0]       rounded;

    always_comb begin
        sum         = acc_q + acc_width'(sample);
        rounded     = sum + round_const;
        window_mean = bitwidth_sample'(rounded >> log2_sample_count);
        complete    = add && !clear && (cnt_q == cnt_last);
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        last_mean_d = last_mean_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (complete) begin
            acc_d       = '0;
            cnt_d       = '0;
            last_mean_d = window_mean;
        end else if (add) begin
            acc_d = sum;
            cnt_d = cnt_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            last_mean_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            last_mean_q <= last_mean_d;
        end
    end

    assign last_mean = last_mean_q;
endmodule

// File: rtl/average_channels.sv
// Multi-channel block averager: channel decode, range check, output register, read mux.
// AVERAGE_ROUNDING_EN (see average_slot) switches the mean to round-half-up.
module average_channels
    import average_pkg::*;
#(
    parameter int unsigned bitwidth_sample   = 12,
    parameter int unsigned channel_count     = 4,
    parameter int unsigned log2_sample_count = 4,
    localparam int unsigned chan_width       = bitwidth_channel(channel_count)
) (
    input  logic                       clock,
    input  logic                       reset,
    average_channels_if.slave          bus,
    input  logic                       clear,
    input  logic [chan_width-1:0]      read_channel,
    output logic [bitwidth_sample-1:0] read_mean,
    output logic                       channel_error
);
    logic [channel_count-1:0]   add;
    logic [channel_count-1:0]   complete;
    logic [bitwidth_sample-1:0] window_mean [channel_count];
    logic [bitwidth_sample-1:0] last_mean   [channel_count];
    logic                       accept;
    logic                       in_range;

    logic [bitwidth_sample-1:0] mean_value_q, mean_value_d;
    logic [chan_width-1:0]      mean_channel_q, mean_channel_d;
    logic                       mean_valid_q, mean_valid_d;
    logic                       channel_error_q, channel_error_d;

    // clear beats a coincident sample, so the sample neither adds nor flags an error.
    assign accept   = bus.sample_valid && !clear;
    assign in_range = 32'(bus.sample_channel) < channel_count;

    for (genvar c = 0; c < channel_count; c++) begin : g_slot
        assign add[c] = accept && in_range && (bus.sample_channel == chan_width'(c));

        average_slot #(
            .bitwidth_sample  (bitwidth_sample),
            .log2_sample_count(log2_sample_count)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .add        (add[c]),
            .clear      (clear),
            .sample     (bus.sample_value),
            .complete   (complete[c]),
            .window_mean(window_mean[c]),
            .last_mean  (last_mean[c])
        );
    end

    // At most one slot completes per cycle since add is one-hot.
    always_comb begin
        mean_valid_d    = |complete;
        mean_value_d    = mean_value_q;
        mean_channel_d  = mean_channel_q;
        channel_error_d = accept && !in_range;
        for (int c = 0; c < channel_count; c++) begin
            if (complete[c]) begin
                mean_value_d   = window_mean[c];
                mean_channel_d = chan_width'(c);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mean_value_q    <= '0;
            mean_channel_q  <= '0;
            mean_valid_q    <= 1'b0;
            channel_error_q <= 1'b0;
        end else begin
            mean_value_q    <= mean_value_d;
            mean_channel_q  <= mean_channel_d;
            mean_valid_q    <= mean_valid_d;
            channel_error_q <= channel_error_d;
        end
    end

    always_comb begin
        read_mean = '0;
        for (int c = 0; c < channel_count; c++) begin
            if (read_channel == chan_width'(c)) begin
                read_mean = last_mean[c];
            end
        end
    end

    assign bus.mean_value   = mean_value_q;
    assign bus.mean_channel = mean_channel_q;
    assign bus.mean_valid   = mean_valid_q;
    assign channel_error    = channel_error_q;
endmodule

// File: tb/tb_average_channels.sv
// Directed bench: 3 channels with 4-sample windows, plus a 1-sample-window instance.
module tb_average_channels;
`ifdef AVERAGE_ROUNDING_EN
    localparam logic [31:0] exp_ch1 = 32'd102;
`else
    localparam logic [31:0] exp_ch1 = 32'd101;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [1:0]  read_channel  = 2'd0;
    logic [1:0]  read_channel0 = 2'd0;
    logic [11:0] read_mean, read_mean0;
    logic        channel_error, channel_error0;
    int          evaluated = 0;
    int          failures  = 0;

    average_channels_if #(.sample_width(12), .channel_width(2)) bus ();
    average_channels_if #(.sample_width(12), .channel_width(2)) bus0 ();

    average_channels #(
        .bitwidth_sample(12), .channel_count(3), .log2_sample_count(2)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .clear(clear),
        .read_channel(read_channel), .read_mean(read_mean), .channel_error(channel_error)
    );

    average_channels #(
        .bitwidth_sample(12), .channel_count(3), .log2_sample_count(0)
    ) dut0 (
        .clock(clock), .reset(reset), .bus(bus0), .clear(clear),
        .read_channel(read_channel0), .read_mean(read_mean0),
        .channel_error(channel_error0)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [11:0] val);
        bus.sample_valid   = 1'b1;
        bus.sample_channel = ch;
        bus.sample_value   = val;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] ch, input logic [31:0] exp);
        read_channel = ch;
        #1;
        check(tag, 32'(read_mean), exp);
    endtask

    initial begin
        bus.sample_valid    = 1'b0;
        bus.sample_channel  = '0;
        bus.sample_value    = '0;
        bus0.sample_valid   = 1'b0;
        bus0.sample_channel = '0;
        bus0.sample_value   = '0;
        tick();
        tick();
        reset = 1'b0;

        check("reset mean_value", 32'(bus.mean_value), 0);
        check("reset mean_channel", 32'(bus.mean_channel), 0);
        check("reset mean_valid", 32'(bus.mean_valid), 0);
        check("reset channel_error", 32'(channel_error), 0);
        read_check("reset read_mean ch0", 2'd0, 0);

        // Ch0 10,20,30,40 -> 25.
        send(2'd0, 12'd10);
        send(2'd0, 12'd20);
        send(2'd0, 12'd30);
        check("ch0 no early pulse", 32'(bus.mean_valid), 0);
        send(2'd0, 12'd40);
        check("ch0 mean_valid", 32'(bus.mean_valid), 1);
        check("ch0 mean_value", 32'(bus.mean_value), 25);
        check("ch0 mean_channel", 32'(bus.mean_channel), 0);
        read_check("ch0 read_mean", 2'd0, 25);
        tick();
        check("ch0 pulse one cycle", 32'(bus.mean_valid), 0);
        check("ch0 mean_value holds", 32'(bus.mean_value), 25);

        // Interleaved ch1 and full-scale ch2: back-to-back completions.
        send(2'd1, 12'd100);
        send(2'd2, 12'd4095);
        send(2'd1, 12'd101);
        send(2'd2, 12'd4095);
        send(2'd1, 12'd102);
        send(2'd2, 12'd4095);
        send(2'd1, 12'd103);
        check("ch1 mean_valid", 32'(bus.mean_valid), 1);
        check("ch1 mean_value", 32'(bus.mean_value), exp_ch1);
        check("ch1 mean_channel", 32'(bus.mean_channel), 1);
        send(2'd2, 12'd4095);
        check("ch2 mean_valid back-to-back", 32'(bus.mean_valid), 1);
        check("ch2 mean_value full scale", 32'(bus.mean_value), 4095);
        check("ch2 mean_channel", 32'(bus.mean_channel), 2);
        read_check("ch1 read_mean", 2'd1, exp_ch1);

        // Ch2 partial window discarded by clear; coincident sample dropped.
        send(2'd2, 12'd5);
        send(2'd2, 12'd7);
        clear = 1'b1;
        send(2'd2, 12'd9);
        clear = 1'b0;
        check("clear no mean_valid", 32'(bus.mean_valid), 0);
        check("clear no channel_error", 32'(channel_error), 0);
        send(2'd2, 12'd8);
        send(2'd2, 12'd8);
        send(2'd2, 12'd8);
        check("ch2 no pulse after clear", 32'(bus.mean_valid), 0);
        read_check("ch2 last_mean retained", 2'd2, 4095);
        send(2'd2, 12'd8);
        check("ch2 new mean_valid", 32'(bus.mean_valid), 1);
        check("ch2 new mean_value", 32'(bus.mean_value), 8);
        read_check("ch2 read_mean updated", 2'd2, 8);

        // Out-of-range channel.
        send(2'd3, 12'd50);
        check("range channel_error", 32'(channel_error), 1);
        check("range no mean_valid", 32'(bus.mean_valid), 0);
        check("range mean_value held", 32'(bus.mean_value), 8);
        tick();
        check("range error one cycle", 32'(channel_error), 0);
        read_check("range ch0 unchanged", 2'd0, 25);

        // Reset mid-window on ch0.
        send(2'd0, 12'd1000);
        send(2'd0, 12'd1000);
        send(2'd0, 12'd1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset mean_value", 32'(bus.mean_value), 0);
        check("mid reset mean_channel", 32'(bus.mean_channel), 0);
        check("mid reset mean_valid", 32'(bus.mean_valid), 0);
        read_check("mid reset read ch1", 2'd1, 0);
        read_check("mid reset read ch2", 2'd2, 0);
        send(2'd0, 12'd12);
        send(2'd0, 12'd12);
        send(2'd0, 12'd12);
        check("post reset no early pulse", 32'(bus.mean_valid), 0);
        send(2'd0, 12'd12);
        check("post reset mean_valid", 32'(bus.mean_valid), 1);
        check("post reset mean_value", 32'(bus.mean_value), 12);

        // Single-sample windows: every sample is its own mean.
        bus0.sample_valid   = 1'b1;
        bus0.sample_channel = 2'd1;
        bus0.sample_value   = 12'd7;
        tick();
        check("l0 first mean_valid", 32'(bus0.mean_valid), 1);
        check("l0 first mean_value", 32'(bus0.mean_value), 7);
        check("l0 first mean_channel", 32'(bus0.mean_channel), 1);
        bus0.sample_value = 12'd9;
        tick();
        bus0.sample_valid = 1'b0;
        check("l0 second mean_valid", 32'(bus0.mean_valid), 1);
        check("l0 second mean_value", 32'(bus0.mean_value), 9);
        read_channel0 = 2'd1;
        #1;
        check("l0 read_mean", 32'(read_mean0), 9);
        tick();
        check("l0 idle mean_valid", 32'(bus0.mean_valid), 0);
        check("l0 no channel_error", 32'(channel_error0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end
endmodule
